// File: rtl/alu_issue_stage_if.sv
// Request/result handshake bundle for alu_issue_stage.
// master = upstream producer / downstream consumer side, slave = the issue stage.
interface alu_issue_stage_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_sel;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_c;
    logic [2:0]       out_sel;

    modport master (
        output in_valid, in_a, in_b, in_sel, out_ready,
        input  in_ready, out_valid, out_y, out_c, out_sel
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, out_ready,
        output in_ready, out_valid, out_y, out_c, out_sel
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Issue/capture stage around a combinational ALU: request FIFO feeding the
// ALU, registered result offered downstream over valid/ready.
//
// Result register states:
//   state     | meaning
//   RES_EMPTY | no result held, out_valid = 0
//   RES_FULL  | result held in out_y/out_c/out_sel, out_valid = 1
module alu_issue_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    alu_issue_stage_if.slave         bus,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_sel,
    input  logic [WIDTH-1:0]         alu_y,
    input  logic                     alu_c,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 3 + 2 * WIDTH;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        RES_EMPTY = 1'b0,
        RES_FULL  = 1'b1
    } res_state_t;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    res_state_t       res_state_q;
    logic [WIDTH-1:0] out_y_q;
    logic             out_c_q;
    logic [2:0]       out_sel_q;

    logic             clear;
    logic             in_ready;
    logic             out_valid;
    logic             empty;
    logic             push;
    logic             can_load;
    logic [EW-1:0]    head;

    assign clear     = rst || flush;
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (res_state_q == RES_FULL);
    assign empty     = (count_q == '0);
    assign push      = bus.in_valid && in_ready;
    assign can_load  = !empty && (!out_valid || bus.out_ready);
    assign head      = mem_q[rd_ptr_q];

    // Head entry is presented to the ALU; zeros when nothing is queued.
    assign alu_sel = empty ? 3'b000 : head[EW-1 -: 3];
    assign alu_a   = empty ? '0 : head[2*WIDTH-1 -: WIDTH];
    assign alu_b   = empty ? '0 : head[WIDTH-1:0];

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_y     = out_y_q;
    assign bus.out_c     = out_c_q;
    assign bus.out_sel   = out_sel_q;
    assign count         = count_q;

    // Occupancy next-state: simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        if (push && !can_load) begin
            count_d = count_q + 1'b1;
        end else if (!push && can_load) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO storage write; a push coinciding with a clear is dropped.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= {bus.in_sel, bus.in_a, bus.in_b};
        end
    end

    // Pointers, occupancy and the result register / its EMPTY-FULL state.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_state_q <= RES_EMPTY;
            out_y_q     <= '0;
            out_c_q     <= 1'b0;
            out_sel_q   <= 3'b000;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (can_load) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                out_y_q     <= alu_y;
                out_c_q     <= alu_c;
                out_sel_q   <= head[EW-1 -: 3];
                res_state_q <= RES_FULL;
            end else if (out_valid && bus.out_ready) begin
                res_state_q <= RES_EMPTY;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU attached to the DUT, queue-based
// reference model checked every cycle, directed vectors and corner sequences.
module tb_alu_issue_stage;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_y;
    logic             alu_c;
    logic [2:0]       count;

    int total = 0;
    int bad   = 0;

    alu_issue_stage_if #(.WIDTH(WIDTH)) bus ();

    alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .bus     (bus),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_sel (alu_sel),
        .alu_y   (alu_y),
        .alu_c   (alu_c),
        .count   (count)
    );

    always #5 clk = ~clk;

    // Opcode meanings: add, sub (c=borrow), and, or, xor, shl (c=msb out),
    // shr (c=lsb out), pass a.
    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] s);
        logic [4:0] r;
        case (s)
            3'd0:    r = {1'b0, a} + {1'b0, b};
            3'd1:    r = {(a < b), 4'(a - b)};
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, a | b};
            3'd4:    r = {1'b0, a ^ b};
            3'd5:    r = {a[3], a[2:0], 1'b0};
            3'd6:    r = {a[0], 1'b0, a[3:1]};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    always_comb {alu_c, alu_y} = alu_f(alu_a, alu_b, alu_sel);

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
    } op_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
        logic [3:0] y;
        logic       c;
    } vec_t;

    // Reference model: queued ops plus one result slot.
    op_t        mq[$];
    logic       m_rv;
    logic [3:0] m_y;
    logic       m_c;
    logic [2:0] m_sel;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic rs, input logic fl, input logic iv,
                        input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                        input logic ordy);
        op_t   hd;
        logic  do_push;
        logic  do_load;
        logic [4:0] r;
        rst           = rs;
        flush         = fl;
        bus.in_valid  = iv;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_sel    = s;
        bus.out_ready = ordy;
        #1;
        if (!rs) begin
            chk("in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
            hd = '{a: 4'd0, b: 4'd0, sel: 3'd0};
            if (mq.size() != 0) hd = mq[0];
            chk("alu_a", 32'(alu_a), 32'(hd.a));
            chk("alu_b", 32'(alu_b), 32'(hd.b));
            chk("alu_sel", 32'(alu_sel), 32'(hd.sel));
        end
        if (rs || fl) begin
            mq.delete();
            m_rv  = 1'b0;
            m_y   = 4'd0;
            m_c   = 1'b0;
            m_sel = 3'd0;
        end else begin
            do_push = iv && (mq.size() != DEPTH);
            do_load = (mq.size() != 0) && (!m_rv || ordy);
            if (do_load) begin
                hd    = mq.pop_front();
                r     = alu_f(hd.a, hd.b, hd.sel);
                m_y   = r[3:0];
                m_c   = r[4];
                m_sel = hd.sel;
                m_rv  = 1'b1;
            end else if (m_rv && ordy) begin
                m_rv = 1'b0;
            end
            if (do_push) mq.push_back('{a: a, b: b, sel: s});
        end
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(mq.size()));
        chk("out_valid", 32'(bus.out_valid), 32'(m_rv));
        chk("out_y", 32'(bus.out_y), 32'(m_y));
        chk("out_c", 32'(bus.out_c), 32'(m_c));
        chk("out_sel", 32'(bus.out_sel), 32'(m_sel));
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, ordy);
    endtask

    vec_t vecs[10];
    logic [3:0] held_y;

    initial begin
        vecs[0] = '{a: 4'd3,  b: 4'd5,  sel: 3'd0, y: 4'd8,  c: 1'b0};
        vecs[1] = '{a: 4'd9,  b: 4'd8,  sel: 3'd0, y: 4'd1,  c: 1'b1};
        vecs[2] = '{a: 4'd5,  b: 4'd3,  sel: 3'd1, y: 4'd2,  c: 1'b0};
        vecs[3] = '{a: 4'd3,  b: 4'd5,  sel: 3'd1, y: 4'd14, c: 1'b1};
        vecs[4] = '{a: 4'd12, b: 4'd10, sel: 3'd2, y: 4'd8,  c: 1'b0};
        vecs[5] = '{a: 4'd12, b: 4'd10, sel: 3'd3, y: 4'd14, c: 1'b0};
        vecs[6] = '{a: 4'd12, b: 4'd10, sel: 3'd4, y: 4'd6,  c: 1'b0};
        vecs[7] = '{a: 4'd9,  b: 4'd0,  sel: 3'd5, y: 4'd2,  c: 1'b1};
        vecs[8] = '{a: 4'd9,  b: 4'd0,  sel: 3'd6, y: 4'd4,  c: 1'b1};
        vecs[9] = '{a: 4'd7,  b: 4'd3,  sel: 3'd7, y: 4'd7,  c: 1'b0};

        m_rv = 1'b0; m_y = 4'd0; m_c = 1'b0; m_sel = 3'd0;

        // Reset and reset values.
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
        bus.in_valid = 1'b0; rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        @(negedge clk);

        // Single-op latency and result vectors.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].sel, 1'b1);
            chk("vec_early_valid", 32'(bus.out_valid), 32'd0);
            chk("vec_count1", 32'(count), 32'd1);
            idle(1'b1);
            chk("vec_valid", 32'(bus.out_valid), 32'd1);
            chk("vec_y", 32'(bus.out_y), 32'(vecs[i].y));
            chk("vec_c", 32'(bus.out_c), 32'(vecs[i].c));
            chk("vec_sel", 32'(bus.out_sel), 32'(vecs[i].sel));
            chk("vec_count0", 32'(count), 32'd0);
            idle(1'b1);
        end

        // Stream of 8 back-to-back ops.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 4'(i), 4'(i + 3), 3'(i), 1'b1);
            chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
            chk("stream_count_le1", 32'(count <= 3'd1), 32'd1);
            if (i > 0) chk("stream_valid", 32'(bus.out_valid), 32'd1);
        end
        idle(1'b1);
        idle(1'b1);

        // Back-pressure to full, then drain through pointer wrap.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 4'(i + 6), 4'(11 - i), 3'(i + 1), 1'b0);
        held_y = bus.out_y;
        chk("full_count", 32'(count), 32'd4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 4'd15, 4'd1, 3'd0, 1'b0);
            chk("full_in_ready", 32'(bus.in_ready), 32'd0);
            chk("held_y", 32'(bus.out_y), 32'(held_y));
        end
        step(1'b0, 1'b0, 1'b1, 4'd15, 4'd1, 3'd0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 4'd15, 4'd1, 3'd0, 1'b1);
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("drained", 32'(count), 32'd0);

        // Simultaneous push/pop at count=2 with a result held.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 4'(i + 1), 4'(i + 2), 3'd0, 1'b0);
        chk("pp_count_before", 32'(count), 32'd2);
        held_y = bus.out_y;
        step(1'b0, 1'b0, 1'b1, 4'd4, 4'd4, 3'd0, 1'b1);
        chk("pp_count_after", 32'(count), 32'd2);
        chk("pp_y_updated", 32'(bus.out_y != held_y), 32'd1);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Flush mid-stream, then the same with rst.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'(i + 5), 4'd1, 3'd0, 1'b0);
        chk("fl_pre_count", 32'(count), 32'd3);
        step(1'b0, 1'b1, 1'b1, 4'd9, 4'd9, 3'd0, 1'b1);
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_y", 32'(bus.out_y), 32'd0);
        idle(1'b1);
        chk("fl_lost", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'(i + 5), 4'd1, 3'd2, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4'd9, 4'd9, 3'd0, 1'b1);
        chk("rs_count", 32'(count), 32'd0);
        chk("rs_valid", 32'(bus.out_valid), 32'd0);
        chk("rs_sel", 32'(bus.out_sel), 32'd0);
        chk("rs_c", 32'(bus.out_c), 32'd0);
        idle(1'b1);
        chk("rs_lost", 32'(bus.out_valid), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'b0, ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
                 4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 8; i++) idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
